// File: rtl/vga_pkg.sv
// Shared constants and FSM encoding for the VGA frame-buffer write path.
package vga_pkg;

    localparam int DEF_H_RES  = 640;
    localparam int DEF_V_RES  = 480;
    localparam int DEF_ADDR_W = 19;
    localparam int DEF_DATA_W = 8;

    localparam int FRAME_PIXELS = DEF_H_RES * DEF_V_RES;

    // Width of the x/y raster coordinates.
    localparam int XY_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FILL   = 2'd2
    } wr_state_t;

endpackage

// File: rtl/fb_raster_counter.sv
// Raster position tracker: x/y coordinates plus the linear frame address,
// built incrementally so that addr == y*H_RES + x without a multiplier.
module fb_raster_counter
    import vga_pkg::*;
#(
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              step,
    output logic [XY_W-1:0]   x,
    output logic [XY_W-1:0]   y,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [XY_W-1:0]   X_LAST   = XY_W'(H_RES - 1);
    localparam logic [XY_W-1:0]   Y_LAST   = XY_W'(V_RES - 1);
    localparam logic [XY_W-1:0]   XY_ONE   = XY_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);

    logic [ADDR_W-1:0] row_base;

    assign last = (x == X_LAST) && (y == Y_LAST);

    // Stepping past the final pixel returns everything to the origin, so
    // the counters already sit at zero when the writer drops back to idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x        <= '0;
            y        <= '0;
            row_base <= '0;
            addr     <= '0;
        end else if (clear || (step && last)) begin
            x        <= '0;
            y        <= '0;
            row_base <= '0;
            addr     <= '0;
        end else if (step) begin
            if (x == X_LAST) begin
                x        <= '0;
                y        <= y + XY_ONE;
                row_base <= row_base + ROW_STEP;
                addr     <= row_base + ROW_STEP;
            end else begin
                x    <= x + XY_ONE;
                addr <= addr + ADDR_ONE;
            end
        end
    end

endmodule

// File: rtl/fb_pixel_writer.sv
// Frame-buffer write engine: streams raster-ordered pixels or a solid fill
// colour into the frame RAM write port, one pixel per clock at most.
module fb_pixel_writer
    import vga_pkg::*;
#(
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_color,
    input  logic              abort,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic              pix_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic [XY_W-1:0]   cur_x,
    output logic [XY_W-1:0]   cur_y
);

    wr_state_t         state, state_nxt;
    logic              step;
    logic              clear;
    logic              last;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] fill_q;

    fb_raster_counter #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W)
    ) u_cnt (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .step  (step),
        .x     (cur_x),
        .y     (cur_y),
        .addr  (addr),
        .last  (last)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // pix_ready is a registered copy of (state == STREAM), so it is a valid
    // acceptance qualifier for the pixel sampled at this edge.
    always_comb begin
        state_nxt = state;
        step      = 1'b0;
        clear     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fill_start) begin
                    state_nxt = ST_FILL;
                    clear     = 1'b1;
                end else if (frame_start) begin
                    state_nxt = ST_STREAM;
                    clear     = 1'b1;
                end
            end
            ST_STREAM: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    clear     = 1'b1;
                end else if (pix_valid && pix_ready) begin
                    step = 1'b1;
                    if (last) state_nxt = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    clear     = 1'b1;
                end else begin
                    step = 1'b1;
                    if (last) state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                clear     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pix_ready  <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            fill_q     <= '0;
        end else begin
            pix_ready  <= (state_nxt == ST_STREAM);
            busy       <= (state_nxt != ST_IDLE);
            wr_en      <= step;
            frame_done <= step && last;
            if (state == ST_IDLE && fill_start)
                fill_q <= fill_color;
            if (step) begin
                wr_addr <= addr;
                wr_data <= (state == ST_FILL) ? fill_q : pix_data;
            end
        end
    end

endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
- Write-side counterpart of the VGA scan-out path: fills the 640x480, 8-bit frame memory that the display side reads at address y*640+x.
- Accepts a raster-ordered pixel stream over a valid/ready handshake, or fills the whole frame with one colour.
- Generates the linear write address incrementally, with no multiplier.
- Sits between a pixel source (camera, pattern generator, SW-driven colour) and the write port of a dual-port frame RAM clocked by the 25 MHz VGA clock.

Parameters:
- H_RES, 640, pixels per line.
- V_RES, 480, lines per frame.
- ADDR_W, 19, frame RAM address width; must satisfy 2^ADDR_W >= H_RES*V_RES.
- DATA_W, 8, pixel colour width (RGB332 code).

Ports:
- clock  in  1  pixel clock (25 MHz VGA clock).
- reset  in  1  asynchronous, active-low reset.
- frame_start  in  1  pulse; begin stream write of a frame at (0,0).
- fill_start  in  1  pulse; begin fill of the whole frame with fill_color.
- fill_color  in  DATA_W  colour used by fill; sampled on fill_start.
- abort  in  1  terminate the current operation.
- pix_valid  in  1  source has a pixel.
- pix_data  in  DATA_W  pixel colour.
- pix_ready  out  1  writer accepts a pixel this cycle.
- wr_en  out  1  frame RAM write enable.
- wr_addr  out  ADDR_W  frame RAM write address.
- wr_data  out  DATA_W  frame RAM write data.
- busy  out  1  operation in progress.
- frame_done  out  1  one-cycle pulse; frame fully written.
- cur_x  out  10  column of the next pixel to be written.
- cur_y  out  10  row of the next pixel to be written.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; counters x, y, row_base and addr are 0.
- All outputs are registered.
- FSM states: IDLE, STREAM, FILL.
- IDLE
  - fill_start=1 -> FILL; latch fill_color.
  - else frame_start=1 -> STREAM.
  - Both asserted in the same cycle: fill wins.
  - x, y and addr are cleared on entry to either state.
- STREAM
  - pix_ready=1 throughout.
  - A pixel is accepted when pix_valid and pix_ready are both high at a rising edge.
  - In the cycle after acceptance: wr_en=1, wr_addr=addr, wr_data=pix_data.
  - No acceptance -> wr_en=0. Stalls of any length are allowed; valid may drop mid-line.
- FILL
  - One write per cycle with wr_data = latched fill_color.
  - pix_ready=0; pix_valid is ignored.
- Address and counter update (on each accepted or filled pixel):
  - addr increments by 1.
  - x increments by 1.
  - At x = H_RES-1: x wraps to 0, y increments, and row_base += H_RES.
  - Invariant: addr == row_base + x == y*H_RES + x. The bench checks this.
- Last pixel (x=H_RES-1, y=V_RES-1):
  - The write issues as normal.
  - frame_done=1 in the same cycle as that final wr_en.
  - State returns to IDLE at the same edge, so pix_ready=0 in that cycle and busy=0 from that cycle on.
  - Exactly H_RES*V_RES writes occur per frame.
- busy = (state != IDLE).
- frame_start and fill_start while busy: ignored, no effect.
- abort (highest priority in STREAM and FILL):
  - Next edge -> IDLE; wr_en=0; no frame_done.
  - A pixel offered in the abort cycle is not accepted.
  - Counters are cleared.
- cur_x and cur_y mirror x and y; they hold at 0 in IDLE.
- Widths: x and y are 10 bits. row_base and addr are ADDR_W bits and never exceed H_RES*V_RES-1.

Decomposition:
- Shared package vga_pkg holds:
  - H_RES, V_RES, ADDR_W and DATA_W defaults;
  - FSM state encoding (2-bit: IDLE=0, STREAM=1, FILL=2);
  - FRAME_PIXELS = H_RES*V_RES.
- One natural sub-module, fb_raster_counter:
  - holds the x/y/row_base/addr counters;
  - inputs: clear and step;
  - outputs: x, y, addr and last.
- The FSM and output registers stay in fb_pixel_writer.

Test Plan:
- Reset mid-STREAM (H_RES=4, V_RES=3): pull reset low after 5 accepts -> all outputs 0 immediately; after release, busy=0 and cur_x=cur_y=0.
- Full stream, pix_valid held high: frame_start then pixels 0x00..0x0B -> 12 writes; wr_addr 0..11 in order with wr_data=addr; frame_done high together with the wr_en at addr 11; busy low from that cycle.
- Back-pressure: pix_valid toggled pseudo-randomly for 640x480 -> exactly 307200 writes.
  - Row boundary: the pixel at (639,0) goes to addr 639 and the next to addr 640 with cur_y=1.
  - Last pixel goes to addr 307199.
- Fill: fill_start with fill_color=0xE0 -> 12 consecutive wr_en cycles, addr 0..11, data 0xE0; pix_ready stays 0; pix_valid is ignored.
- Simultaneous and ignored starts: fill_start and frame_start in the same IDLE cycle -> FILL. A frame_start pulse during FILL is ignored, giving no second frame_done.
- Abort: abort asserted after the 6th accept in STREAM -> no further wr_en, no frame_done, busy=0 the next cycle. A following frame_start restarts at addr 0.
